// File: rtl/alu_result_encoder_pkg.sv
// -----------------------------------------------------------------------------
// alu_result_encoder_pkg
// Shared definitions for the ALU function decoder and the result encoder:
//   - alu_func_e  : 2-bit function codes (ARITH, LOGIC, CMP, SHIFT)
//   - occ_state_e : occupancy state of the 2-entry result buffer
// -----------------------------------------------------------------------------
package alu_result_encoder_pkg;

    typedef enum logic [1:0] {
        ARITH = 2'b00,
        LOGIC = 2'b01,
        CMP   = 2'b10,
        SHIFT = 2'b11
    } alu_func_e;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } occ_state_e;

    localparam int unsigned FUNC_W = 2;

endpackage : alu_result_encoder_pkg

// File: rtl/alu_result_encoder_fifo2.sv
// -----------------------------------------------------------------------------
// alu_result_fifo2
// Two-entry valid/ready FIFO with a registered head output.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   push_i, push_data_i : write request and entry (accepted when in_ready_o)
//   in_ready_o          : buffer has a free slot
//   pop_ready_i         : consumer takes the head entry this cycle
//   out_valid_o         : out_data_o holds a valid head entry
//   out_data_o          : registered head entry, zero while empty
// -----------------------------------------------------------------------------
module alu_result_fifo2
    import alu_result_encoder_pkg::*;
#(
    parameter int unsigned DW = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    output logic          in_ready_o,
    input  logic          pop_ready_i,
    output logic          out_valid_o,
    output logic [DW-1:0] out_data_o
);

    occ_state_e    state_q, state_d;
    logic          wptr_q, wptr_d;
    logic          rptr_q, rptr_d;
    logic [DW-1:0] mem_q [2];
    logic [DW-1:0] head_q, head_d;
    logic          do_push, do_pop;

    assign in_ready_o  = (state_q != FULL);
    assign out_valid_o = (state_q != EMPTY);
    assign out_data_o  = head_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        do_push = push_i && in_ready_o;
        do_pop  = out_valid_o && pop_ready_i;
        wptr_d  = wptr_q ^ do_push;   // 1-bit pointers wrap modulo 2
        rptr_d  = rptr_q ^ do_pop;

        unique case (state_q)
            EMPTY:   if (do_push) state_d = ONE;
            ONE: begin
                if (do_push && !do_pop)      state_d = FULL;
                else if (do_pop && !do_push) state_d = EMPTY;
            end
            FULL:    if (do_pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase

        // The next head is the entry being written when it lands exactly
        // where the read pointer will point; otherwise it is already stored.
        if (state_d == EMPTY)
            head_d = '0;
        else if (do_push && (rptr_d == wptr_q))
            head_d = push_data_i;
        else
            head_d = mem_q[rptr_d];
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q <= EMPTY;
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            head_q  <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            head_q  <= head_d;
        end
    end

    // NOTE: storage is not reset; stale slots are unreachable because the state and pointers are.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= push_data_i;
    end

endmodule : alu_result_fifo2

// File: rtl/alu_result_encoder.sv
// -----------------------------------------------------------------------------
// alu_result_encoder
// Selects the result of whichever ALU unit pulsed its flag, tags it with the
// unit's function code and queues it in a 2-entry buffer for downstream.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   *_out / *_flag           : signed result and valid pulse of each unit
//   out_ready                : downstream accepts the head entry
//   err_clr                  : clears the sticky error bits
//   alu_out / alu_func_out   : registered head result and its source code
//   out_valid / in_ready     : buffer handshake status
//   onehot_err               : sticky, several flags seen in one cycle
//   drop_err                 : sticky, a valid result arrived while full
// -----------------------------------------------------------------------------
module alu_result_encoder
    import alu_result_encoder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] arith_out,
    input  logic signed [WIDTH-1:0] logic_out,
    input  logic signed [WIDTH-1:0] cmp_out,
    input  logic signed [WIDTH-1:0] shift_out,
    input  logic                    arith_flag,
    input  logic                    logic_flag,
    input  logic                    cmp_flag,
    input  logic                    shift_flag,
    input  logic                    out_ready,
    input  logic                    err_clr,
    output logic signed [WIDTH-1:0] alu_out,
    output logic [FUNC_W-1:0]       alu_func_out,
    output logic                    out_valid,
    output logic                    in_ready,
    output logic                    onehot_err,
    output logic                    drop_err
);

    localparam int unsigned DW = WIDTH + FUNC_W;

    logic [3:0]       flags;
    logic             single_flag, multi_flag;
    logic [WIDTH-1:0] sel_data;
    alu_func_e        sel_code;
    logic [DW-1:0]    head_data;
    logic             onehot_err_q, onehot_err_d;
    logic             drop_err_q, drop_err_d;

    assign flags       = {shift_flag, cmp_flag, logic_flag, arith_flag};
    assign single_flag = ($countones(flags) == 1);
    assign multi_flag  = ($countones(flags) > 1);

    // Priority order is irrelevant: the selection is only pushed when a
    // single flag is high.
    always_comb begin
        sel_data = arith_out;
        sel_code = ARITH;
        if (logic_flag) begin
            sel_data = logic_out;
            sel_code = LOGIC;
        end else if (cmp_flag) begin
            sel_data = cmp_out;
            sel_code = CMP;
        end else if (shift_flag) begin
            sel_data = shift_out;
            sel_code = SHIFT;
        end
    end

    alu_result_fifo2 #(.DW(DW)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (single_flag),
        .push_data_i ({sel_data, sel_code}),
        .in_ready_o  (in_ready),
        .pop_ready_i (out_ready),
        .out_valid_o (out_valid),
        .out_data_o  (head_data)
    );

    assign alu_out      = head_data[DW-1:FUNC_W];
    assign alu_func_out = head_data[FUNC_W-1:0];

    // An error event in the same cycle as err_clr wins.
    always_comb begin
        onehot_err_d = onehot_err_q;
        drop_err_d   = drop_err_q;
        if (err_clr) begin
            onehot_err_d = 1'b0;
            drop_err_d   = 1'b0;
        end
        if (multi_flag)              onehot_err_d = 1'b1;
        if (single_flag && !in_ready) drop_err_d  = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            onehot_err_q <= 1'b0;
            drop_err_q   <= 1'b0;
        end else begin
            onehot_err_q <= onehot_err_d;
            drop_err_q   <= drop_err_d;
        end
    end

    assign onehot_err = onehot_err_q;
    assign drop_err   = drop_err_q;

endmodule : alu_result_encoder

// File: tb/tb_alu_result_encoder.sv
// -----------------------------------------------------------------------------
// tb_alu_result_encoder
// Directed scenarios followed by random traffic, every cycle compared against
// a queue-based reference of the result buffer and the sticky error bits.
// -----------------------------------------------------------------------------
module tb_alu_result_encoder;

    localparam int W = 16;

    typedef struct {
        logic signed [W-1:0] data;
        logic [1:0]          code;
    } entry_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic signed [W-1:0] arith_out = '0, logic_out = '0, cmp_out = '0, shift_out = '0;
    logic                arith_flag = 1'b0, logic_flag = 1'b0, cmp_flag = 1'b0, shift_flag = 1'b0;
    logic                out_ready = 1'b0;
    logic                err_clr = 1'b0;
    logic signed [W-1:0] alu_out;
    logic [1:0]          alu_func_out;
    logic                out_valid, in_ready, onehot_err, drop_err;

    int     n_checks = 0;
    int     n_errors = 0;
    entry_t mq[$];
    logic   m_onehot = 1'b0;
    logic   m_drop   = 1'b0;

    always #5 clk = ~clk;

    alu_result_encoder #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .arith_out    (arith_out),
        .logic_out    (logic_out),
        .cmp_out      (cmp_out),
        .shift_out    (shift_out),
        .arith_flag   (arith_flag),
        .logic_flag   (logic_flag),
        .cmp_flag     (cmp_flag),
        .shift_flag   (shift_flag),
        .out_ready    (out_ready),
        .err_clr      (err_clr),
        .alu_out      (alu_out),
        .alu_func_out (alu_func_out),
        .out_valid    (out_valid),
        .in_ready     (in_ready),
        .onehot_err   (onehot_err),
        .drop_err     (drop_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        entry_t head;
        head.data = '0;
        head.code = 2'b00;
        if (mq.size() > 0) head = mq[0];
        check("out_valid",    32'(out_valid),  32'(mq.size() > 0));
        check("in_ready",     32'(in_ready),   32'(mq.size() < 2));
        check("alu_out",      32'(alu_out),    32'(head.data));
        check("alu_func_out", 32'(alu_func_out), 32'(head.code));
        check("onehot_err",   32'(onehot_err), 32'(m_onehot));
        check("drop_err",     32'(drop_err),   32'(m_drop));
    endtask

    // Apply one clock edge to the reference using the current inputs, then
    // let the DUT take the same edge and compare.
    task automatic tick();
        logic [3:0]          f;
        logic signed [W-1:0] vals [4];
        int                  nf;
        bit                  room;
        entry_t              e;
        f    = {shift_flag, cmp_flag, logic_flag, arith_flag};
        vals = '{arith_out, logic_out, cmp_out, shift_out};
        nf   = 0;
        for (int i = 0; i < 4; i++) if (f[i]) nf++;
        room = (mq.size() < 2);
        if (mq.size() > 0 && out_ready) void'(mq.pop_front());
        if (nf == 1) begin
            for (int i = 0; i < 4; i++) begin
                if (f[i]) begin
                    e.data = vals[i];
                    e.code = 2'(i);
                end
            end
            if (room) mq.push_back(e);
        end
        if (err_clr) begin
            m_onehot = 1'b0;
            m_drop   = 1'b0;
        end
        if (nf > 1) m_onehot = 1'b1;
        if (nf == 1 && !room) m_drop = 1'b1;
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic set_flags(input logic [3:0] f);
        {shift_flag, cmp_flag, logic_flag, arith_flag} = f;
    endtask

    initial begin
        // Reset
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1 check_model();
        check("reset_func", 32'(alu_func_out), 32'd0);

        // Single cmp result flows straight through
        out_ready = 1'b1;
        cmp_out = -16'sd5;
        set_flags(4'b0100);
        tick();
        check("cmp_value", 32'(alu_out), -32'sd5);
        check("cmp_code",  32'(alu_func_out), 32'd2);
        set_flags(4'b0000);
        tick();
        check("cmp_popped", 32'(out_valid), 32'd0);

        // Fill while stalled, third result is dropped, then drain in order
        out_ready = 1'b0;
        arith_out = 16'sd7;  set_flags(4'b0001); tick();
        shift_out = 16'sd3;  set_flags(4'b1000); tick();
        check("full_in_ready", 32'(in_ready), 32'd0);
        logic_out = 16'sd9;  set_flags(4'b0010); tick();
        check("drop_set", 32'(drop_err), 32'd1);
        check("hold_7",   32'(alu_out), 32'd7);
        set_flags(4'b0000);
        out_ready = 1'b1;
        tick();
        check("drain_3",      32'(alu_out), 32'd3);
        check("drain_3_code", 32'(alu_func_out), 32'd3);
        tick();
        err_clr = 1'b1; tick(); err_clr = 1'b0;

        // Two flags at once: nothing queued, sticky error until cleared
        set_flags(4'b0011);
        tick();
        check("onehot_set", 32'(onehot_err), 32'd1);
        set_flags(4'b0000);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("onehot_clr", 32'(onehot_err), 32'd0);

        // Clear and new multi-flag event in the same cycle: error wins
        set_flags(4'b1100); err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("clr_vs_set", 32'(onehot_err), 32'd1);
        set_flags(4'b0000); err_clr = 1'b1; tick(); err_clr = 1'b0;

        // ONE with simultaneous push and pop
        out_ready = 1'b0;
        arith_out = 16'sd100; set_flags(4'b0001); tick();
        out_ready = 1'b1;
        shift_out = -16'sd32768; set_flags(4'b1000); tick();
        check("pp_value", 32'(alu_out), -32'sd32768);
        check("pp_code",  32'(alu_func_out), 32'd3);
        check("pp_ready", 32'(in_ready), 32'd1);
        set_flags(4'b0000); tick();

        // Asynchronous reset while full
        out_ready = 1'b0;
        cmp_out = 16'sd11;   set_flags(4'b0100); tick();
        logic_out = 16'sd12; set_flags(4'b0010); tick();
        set_flags(4'b0011); tick();
        set_flags(4'b0000);
        #3 rst = 1'b1;
        #1;
        mq.delete();
        m_onehot = 1'b0;
        m_drop   = 1'b0;
        check_model();
        @(negedge clk) rst = 1'b0;
        tick();

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            int r;
            arith_out = W'($urandom);
            logic_out = W'($urandom);
            cmp_out   = W'($urandom);
            shift_out = W'($urandom);
            r = int'($urandom_range(0, 9));
            if (r < 4)      set_flags(4'b0000);
            else if (r < 8) set_flags(4'(1 << $urandom_range(0, 3)));
            else            set_flags(4'($urandom));
            out_ready = ($urandom_range(0, 9) < 6);
            err_clr   = ($urandom_range(0, 9) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_alu_result_encoder

// File: doc/alu_result_encoder.md
ALU_RESULT_ENCODER -- requirements
Module: alu_result_encoder

Interface
REQ-001 Parameter: WIDTH, 16, width of each signed unit result and of alu_out.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 arith_out, logic_out, cmp_out, shift_out  in  WIDTH each  signed result of each ALU unit.
REQ-005 arith_flag, logic_flag, cmp_flag, shift_flag  in  1 each  result-valid pulse of each unit.
REQ-006 out_ready  in  1  downstream accepts the current output entry.
REQ-007 err_clr  in  1  clears the sticky error bits.
REQ-008 alu_out  out  WIDTH  selected result at the head of the buffer.
REQ-009 alu_func_out  out  2  encoded source unit of alu_out.
REQ-010 out_valid  out  1  alu_out/alu_func_out hold a valid entry.
REQ-011 in_ready  out  1  buffer can accept a result this cycle.
REQ-012 onehot_err  out  1  sticky: more than one flag was high in one cycle.
REQ-013 drop_err  out  1  sticky: a valid single flag arrived while in_ready=0.

Function
REQ-014 Encoding SHALL be the inverse of the ALU function decode: arith 2'b00, logic 2'b01, cmp 2'b10, shift 2'b11.
REQ-015 Push: exactly one flag high and in_ready=1 -> {selected result, code} written to the 2-entry buffer at that edge.
REQ-016 Zero flags high -> no push, no error.
REQ-017 Two or more flags high -> no push, onehot_err set at that edge, regardless of in_ready.
REQ-018 Exactly one flag high with in_ready=0 -> result discarded, drop_err set.
REQ-019 Pop: out_valid=1 and out_ready=1 -> head entry removed at that edge.
REQ-020 Occupancy FSM states EMPTY, ONE, FULL; in_ready=1 in EMPTY and ONE, 0 in FULL; out_valid=1 in ONE and FULL.
REQ-021 Transitions: EMPTY+push->ONE; ONE+push only->FULL; ONE+pop only->EMPTY; ONE+push+pop->ONE (new entry becomes head next cycle); FULL+pop->ONE; all others hold.
REQ-022 Latency: result pushed at edge N is visible on alu_out/alu_func_out from cycle after edge N when the buffer was EMPTY; order strictly FIFO.
REQ-023 alu_out and alu_func_out SHALL be registered, hold stable while out_valid=1 and out_ready=0, and be zero when out_valid=0.
REQ-024 Results pass unmodified (no sign extension or truncation; width WIDTH end to end).
REQ-025 err_clr=1 clears both sticky bits at the edge; an error event in the same cycle wins (bit stays/becomes 1).
REQ-026 Buffer read/write pointers are 1 bit and wrap modulo 2.

Reset
REQ-027 rst=1 asynchronously forces state EMPTY, pointers 0, alu_out=0, alu_func_out=2'b00, out_valid=0, in_ready=1, onehot_err=0, drop_err=0.
REQ-028 Reset asserted mid-transfer SHALL discard all buffered entries; no partial entry survives deassertion.

Structure
REQ-029 Shared package SHALL hold the 2-bit function codes (ARITH, LOGIC, CMP, SHIFT) and the FSM state type, used by both this block and the ALU function decoder.
REQ-030 One sub-module alu_result_fifo2 (2-entry, WIDTH+2 bit, valid/ready) is natural; select/encode and error logic stay in the top.

Verification
REQ-031 Reset, then cmp_flag=1 with cmp_out=-5 for one cycle, out_ready=1 -> next cycle out_valid=1, alu_out=-5, alu_func_out=2'b10, then out_valid=0.
REQ-032 out_ready=0; push arith 7, shift 3, then logic 9 -> first two held in order, in_ready=0 after second, logic 9 dropped, drop_err=1; release out_ready -> 7/00 then 3/11.
REQ-033 arith_flag=1 and logic_flag=1 same cycle -> no push, out_valid stays 0, onehot_err=1; err_clr pulse -> onehot_err=0.
REQ-034 State ONE, simultaneous push (shift -32768) and pop -> state stays ONE, next head alu_out=-32768, alu_func_out=2'b11.
REQ-035 FULL buffer, assert rst asynchronously mid-cycle -> outputs immediately 0, out_valid=0, in_ready=1, errors 0.
REQ-036 err_clr and a new multi-flag event same cycle -> onehot_err remains 1.
